// File: rtl/led_scan_pwm_driver_if.sv
// Pixel load, swap request and scan-out signals
// of the LED scan PWM driver.
interface led_scan_pwm_driver_if #(
    parameter int CH    = 16,
    parameter int LINES = 32
);
    logic                     DAI;
    logic                     DEN;
    logic                     Vsync;
    logic                     mode;
    logic [CH-1:0]            OUT;
    logic                     frame_rdy;
    logic [$clog2(LINES)-1:0] scan_line;
    logic                     frame_start;

    modport master (
        output DAI, DEN, Vsync, mode,
        input  OUT, frame_rdy, scan_line, frame_start
    );

    modport slave (
        input  DAI, DEN, Vsync, mode,
        output OUT, frame_rdy, scan_line, frame_start
    );
endinterface

// File: rtl/led_scan_pwm_driver.sv
// Double-buffered serial grayscale loader with
// line-scanned single or segmented PWM output.
module led_scan_pwm_driver #(
    parameter int CH      = 16,
    parameter int LINES   = 32,
    parameter int GS_BITS = 16,
    parameter int SEG     = 2
) (
    input  logic                 GCK,
    input  logic                 rst,
    led_scan_pwm_driver_if.slave bus
);
    localparam int NPIX   = CH * LINES;
    localparam int ADDR_W = $clog2(NPIX);
    localparam int LINE_W = $clog2(LINES);
    localparam int BIT_W  = $clog2(GS_BITS);
    localparam int SEG_W  = $clog2(SEG);

    typedef logic [GS_BITS-1:0] pix_t;

    localparam pix_t PC_LAST0 = '1;
    localparam pix_t PC_LAST1 =
        GS_BITS'((1 << (GS_BITS - SEG_W)) - 1);
    localparam logic [ADDR_W-1:0] PIX_LAST =
        ADDR_W'(NPIX - 1);
    localparam logic [LINE_W-1:0] LINE_LAST =
        LINE_W'(LINES - 1);
    localparam logic [BIT_W-1:0] BIT_LAST =
        BIT_W'(GS_BITS - 1);
    localparam logic [SEG_W-1:0] SEG_LAST =
        SEG_W'(SEG - 1);

    pix_t              mem_q [2][NPIX];
    pix_t              mem_d [2][NPIX];
    pix_t              shift_q, shift_d;
    logic [BIT_W-1:0]  cnt_bit_q, cnt_bit_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic              frame_rdy_q, frame_rdy_d;
    logic              front_q, front_d;
    logic              swap_pend_q, swap_pend_d;
    logic              vs_q, vs_d;
    logic              mode_q, mode_d;
    pix_t              pc_q, pc_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [CH-1:0]     out_q, out_d;
    logic [LINE_W-1:0] scan_line_q, scan_line_d;
    logic              fstart_q, fstart_d;

    logic              pc_wrap;
    logic              line_wrap;
    logic              frame_end;
    logic [ADDR_W-1:0] rd_base;

    // Mode 1 spreads v over SEG slots; the remainder
    // goes one count each to the earliest segments.
    function automatic pix_t duty_of(
        input pix_t             v,
        input logic [SEG_W-1:0] s,
        input logic             m
    );
        pix_t d;
        d = v;
        if (m) begin
            d = (v >> SEG_W)
              + pix_t'(s < v[SEG_W-1:0]);
        end
        return d;
    endfunction

    // Scan counters: pc within a line, line within a
    // segment, segment within a frame (mode 1 only).
    always_comb begin
        pc_wrap   = mode_q ? (pc_q == PC_LAST1)
                           : (pc_q == PC_LAST0);
        line_wrap = pc_wrap && (line_q == LINE_LAST);
        frame_end = line_wrap
                 && (!mode_q || (seg_q == SEG_LAST));
        pc_d   = pc_wrap ? '0 : pc_q + 1'b1;
        line_d = line_q;
        seg_d  = seg_q;
        mode_d = mode_q;
        if (pc_wrap) begin
            line_d = line_wrap ? '0 : line_q + 1'b1;
        end
        if (line_wrap && mode_q) begin
            seg_d = seg_q + 1'b1;
        end
        if (frame_end) begin
            seg_d  = '0;
            mode_d = bus.mode;
        end
    end

    // Serial load into the back buffer, and buffer
    // swap on the frame boundary once requested.
    always_comb begin
        mem_d       = mem_q;
        shift_d     = shift_q;
        cnt_bit_d   = cnt_bit_q;
        pix_addr_d  = pix_addr_q;
        frame_rdy_d = frame_rdy_q;
        front_d     = front_q;
        swap_pend_d = swap_pend_q;
        vs_d        = bus.Vsync;
        if (bus.DEN && !frame_rdy_q) begin
            shift_d[cnt_bit_q] = bus.DAI;
            if (cnt_bit_q == BIT_LAST) begin
                mem_d[!front_q][pix_addr_q] = shift_d;
                cnt_bit_d = '0;
                if (pix_addr_q == PIX_LAST) begin
                    pix_addr_d  = '0;
                    frame_rdy_d = 1'b1;
                end else begin
                    pix_addr_d = pix_addr_q + 1'b1;
                end
            end else begin
                cnt_bit_d = cnt_bit_q + 1'b1;
            end
        end
        // A swap on this boundary wins over a Vsync
        // edge arriving in the same cycle.
        if (frame_end && swap_pend_q) begin
            front_d     = !front_q;
            frame_rdy_d = 1'b0;
            swap_pend_d = 1'b0;
        end else if (bus.Vsync && !vs_q
                     && frame_rdy_q) begin
            swap_pend_d = 1'b1;
        end
    end

    // PWM compare of the current front-buffer line.
    always_comb begin
        rd_base = ADDR_W'(int'(line_q) * CH);
        out_d   = '0;
        for (int c = 0; c < CH; c++) begin
            out_d[c] = pc_q < duty_of(
                mem_q[front_q][rd_base + ADDR_W'(c)],
                seg_q, mode_q);
        end
        scan_line_d = line_q;
        fstart_d    = (pc_q == '0) && (line_q == '0)
                   && (seg_q == '0);
    end

    // State and registered outputs.
    always_ff @(posedge GCK or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < NPIX; a++) begin
                    mem_q[b][a] <= '0;
                end
            end
            shift_q     <= '0;
            cnt_bit_q   <= '0;
            pix_addr_q  <= '0;
            frame_rdy_q <= 1'b0;
            front_q     <= 1'b0;
            swap_pend_q <= 1'b0;
            vs_q        <= 1'b0;
            mode_q      <= 1'b0;
            pc_q        <= '0;
            line_q      <= '0;
            seg_q       <= '0;
            out_q       <= '0;
            scan_line_q <= '0;
            fstart_q    <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            shift_q     <= shift_d;
            cnt_bit_q   <= cnt_bit_d;
            pix_addr_q  <= pix_addr_d;
            frame_rdy_q <= frame_rdy_d;
            front_q     <= front_d;
            swap_pend_q <= swap_pend_d;
            vs_q        <= vs_d;
            mode_q      <= mode_d;
            pc_q        <= pc_d;
            line_q      <= line_d;
            seg_q       <= seg_d;
            out_q       <= out_d;
            scan_line_q <= scan_line_d;
            fstart_q    <= fstart_d;
        end
    end

    assign bus.OUT         = out_q;
    assign bus.frame_rdy   = frame_rdy_q;
    assign bus.scan_line   = scan_line_q;
    assign bus.frame_start = fstart_q;
endmodule
